// File: rtl/dart_game_ctrl.sv
// dart_game_ctrl: two-player dart scoring and turn controller with ring scoring, bust and win rules.
// Optional macro DOUBLE_OUT_EN: finishing to zero needs a 50 or 30 dart; reaching 1 is a bust.
module dart_game_ctrl #(
  parameter int START_PT       = 301,
  parameter int DARTS_PER_TURN = 3,
  parameter int GAP_CYC        = 4,
  parameter int CX             = 14,
  parameter int CY             = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dart_come_i,
  input  logic [7:0] dart_position_x_i,
  input  logic [7:0] dart_position_y_i,
  output logic       game_set_o,
  output logic       player_1_done_o,
  output logic       player_2_done_o,
  output logic       player_1_win_o,
  output logic       player_2_win_o,
  output logic [8:0] player_1_pt_o,
  output logic [8:0] player_2_pt_o
);
  localparam int CW = $clog2(DARTS_PER_TURN + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  typedef enum logic [2:0] {IDLE, SCORE, UPDATE, DONE, GAP, OVER} state_t;
  state_t          st_q;
  logic [7:0]      x_q, y_q;
  logic [5:0]      val_q;
  logic [8:0]      p1_q, p2_q, snap_q;
  logic            cur_q, turn_end_q, set_q, win1_q, win2_q, done1_q, done2_q;
  logic [CW-1:0]   cnt_q;
  logic [GW-1:0]   gap_q;
  logic signed [16:0] ex_d, ey_d, sx_d, sy_d;
  logic [16:0]     d2_d;
  logic [5:0]      val_d;
  logic [8:0]      cur_pt_d, nxt_pt_d;
  logic signed [9:0] rem_d;
  logic            win_d, bust_d;
  always_comb begin
    ex_d = $signed({9'd0, x_q}) - 17'(CX);
    ey_d = $signed({9'd0, y_q}) - 17'(CY);
    sx_d = ex_d * ex_d;
    sy_d = ey_d * ey_d;
    d2_d = $unsigned(sx_d) + $unsigned(sy_d);
    val_d = d2_d <= 17'd1   ? 6'd50 :
            d2_d <= 17'd9   ? 6'd25 :
            d2_d <= 17'd64  ? 6'd10 :
            d2_d <= 17'd100 ? 6'd30 :
            d2_d <= 17'd169 ? 6'd5  :
            d2_d <= 17'd196 ? 6'd15 : 6'd0;
    cur_pt_d = cur_q ? p2_q : p1_q;
    rem_d = $signed({1'b0, cur_pt_d}) - $signed({4'd0, val_q});
`ifdef DOUBLE_OUT_EN
    win_d  = rem_d == 10'sd0 && (val_q == 6'd50 || val_q == 6'd30);
    bust_d = rem_d < 10'sd0 || rem_d == 10'sd1 || (rem_d == 10'sd0 && !win_d);
`else
    win_d  = rem_d == 10'sd0;
    bust_d = rem_d < 10'sd0;
`endif
    nxt_pt_d = bust_d ? snap_q : win_d ? 9'd0 : rem_d[8:0];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= IDLE; x_q <= '0; y_q <= '0; val_q <= '0;
      p1_q <= 9'(START_PT); p2_q <= 9'(START_PT); snap_q <= 9'(START_PT);
      cur_q <= 1'b0; turn_end_q <= 1'b0; set_q <= 1'b0; win1_q <= 1'b0; win2_q <= 1'b0;
      done1_q <= 1'b0; done2_q <= 1'b0; cnt_q <= '0; gap_q <= '0;
    end else begin
      case (st_q)
        IDLE: if (dart_come_i) begin
          x_q <= dart_position_x_i;
          y_q <= dart_position_y_i;
          st_q <= SCORE;
        end
        SCORE: begin
          val_q <= val_d;
          st_q <= UPDATE;
        end
        UPDATE: begin
          if (cur_q) p2_q <= nxt_pt_d;
          else p1_q <= nxt_pt_d;
          done1_q <= !cur_q;
          done2_q <= cur_q;
          turn_end_q <= bust_d || (!win_d && cnt_q == CW'(DARTS_PER_TURN - 1));
          if (!bust_d && !win_d) cnt_q <= cnt_q + 1'b1;
          if (win_d) begin
            set_q <= 1'b1;
            win1_q <= !cur_q;
            win2_q <= cur_q;
          end
          st_q <= DONE;
        end
        DONE: begin
          done1_q <= 1'b0;
          done2_q <= 1'b0;
          gap_q <= '0;
          st_q <= set_q ? OVER : GAP;
          // hand over after the pulse so the done flag names the thrower
          if (!set_q && turn_end_q) begin
            cur_q <= !cur_q;
            cnt_q <= '0;
            snap_q <= cur_q ? p1_q : p2_q;
            turn_end_q <= 1'b0;
          end
        end
        GAP: begin
          gap_q <= gap_q + 1'b1;
          if (gap_q == GW'(GAP_CYC - 1)) st_q <= IDLE;
        end
        OVER: st_q <= OVER;
        default: st_q <= IDLE;
      endcase
    end
  end
  assign game_set_o      = set_q;
  assign player_1_done_o = done1_q;
  assign player_2_done_o = done2_q;
  assign player_1_win_o  = win1_q;
  assign player_2_win_o  = win2_q;
  assign player_1_pt_o   = p1_q;
  assign player_2_pt_o   = p2_q;
endmodule

// File: tb/tb_dart_game_ctrl.sv
// tb_dart_game_ctrl: two controllers (START_PT 301 and 60) fed the same darts, checked against a reference game model.
module tb_dart_game_ctrl;
  logic clk = 1'b0, reset = 1'b1, come = 1'b0;
  logic [7:0] px = '0, py = '0;
  logic a_gs, a_d1, a_d2, a_w1, a_w2, b_gs, b_d1, b_d2, b_w1, b_w2;
  logic [8:0] a_p1, a_p2, b_p1, b_p2;
  typedef logic [22:0] exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int compared = 0, mismatched = 0;
  int m_pts[2][2];
  int m_snap[2], m_cur[2], m_cnt[2];
  bit m_over[2];
  bit m_win[2][2];
  int last_a = 0, last_b = 0, nb = 0, n0;

  always #5 clk = ~clk;

  dart_game_ctrl #(.START_PT(301)) u_a (
    .clk(clk), .reset(reset), .dart_come_i(come), .dart_position_x_i(px), .dart_position_y_i(py),
    .game_set_o(a_gs), .player_1_done_o(a_d1), .player_2_done_o(a_d2),
    .player_1_win_o(a_w1), .player_2_win_o(a_w2), .player_1_pt_o(a_p1), .player_2_pt_o(a_p2));
  dart_game_ctrl #(.START_PT(60)) u_b (
    .clk(clk), .reset(reset), .dart_come_i(come), .dart_position_x_i(px), .dart_position_y_i(py),
    .game_set_o(b_gs), .player_1_done_o(b_d1), .player_2_done_o(b_d2),
    .player_1_win_o(b_w1), .player_2_win_o(b_w2), .player_1_pt_o(b_p1), .player_2_pt_o(b_p2));

  function automatic int ring(input int x, input int y);
    int d;
    d = (x - 14) * (x - 14) + (y - 14) * (y - 14);
    return d <= 1 ? 50 : d <= 9 ? 25 : d <= 64 ? 10 : d <= 100 ? 30 : d <= 169 ? 5 : d <= 196 ? 15 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pts[0][0] = 301; m_pts[0][1] = 301; m_pts[1][0] = 60; m_pts[1][1] = 60;
    m_snap[0] = 301; m_snap[1] = 60;
    for (int g = 0; g < 2; g++) begin
      m_cur[g] = 0; m_cnt[g] = 0; m_over[g] = 0; m_win[g][0] = 0; m_win[g][1] = 0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic model_dart(input int g, input int v);
    int c, rem;
    bit bust, win, te;
    exp_t e;
    if (m_over[g]) return;
    c = m_cur[g];
    rem = m_pts[g][c] - v;
`ifdef DOUBLE_OUT_EN
    win = rem == 0 && (v == 50 || v == 30);
    bust = rem < 0 || rem == 1 || (rem == 0 && !win);
`else
    win = rem == 0;
    bust = rem < 0;
`endif
    te = 0;
    if (bust) begin
      m_pts[g][c] = m_snap[g];
      te = 1;
    end else if (win) begin
      m_pts[g][c] = 0;
      m_win[g][c] = 1;
      m_over[g] = 1;
    end else begin
      m_pts[g][c] = rem;
      m_cnt[g]++;
      te = m_cnt[g] == 3;
    end
    e = {c == 0, c == 1, 9'(m_pts[g][0]), 9'(m_pts[g][1]), m_win[g][0], m_win[g][1], m_over[g]};
    if (g == 0) qa.push_back(e);
    else qb.push_back(e);
    if (te) begin
      m_cur[g] = 1 - c;
      m_cnt[g] = 0;
      m_snap[g] = m_pts[g][1 - c];
    end
  endtask

  task automatic throw(input int x, input int y);
    @(negedge clk);
    come = 1'b1; px = 8'(x); py = 8'(y);
    model_dart(0, ring(x, y));
    model_dart(1, ring(x, y));
    @(posedge clk);
    #1 come = 1'b0;
    for (int i = 0; i < 12 && (qa.size() + qb.size()) != 0; i++) begin
      @(posedge clk);
      #2;
    end
    chk("done_drain", qa.size() + qb.size(), 0);
    repeat (6) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (a_d1 || a_d2) begin
        last_a = a_d1 ? 1 : 2;
        compared++;
        assert (qa.size() != 0 && !(a_d1 && a_d2)) else begin
          mismatched++;
          $error("FAIL a_done observed=%b%b expected=single_expected_pulse", a_d1, a_d2);
        end
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          compared++;
          assert ({a_d1, a_d2, a_p1, a_p2, a_w1, a_w2, a_gs} === ea) else begin
            mismatched++;
            $error("FAIL a_dart observed=%h expected=%h", {a_d1, a_d2, a_p1, a_p2, a_w1, a_w2, a_gs}, ea);
          end
        end
      end
      if (b_d1 || b_d2) begin
        last_b = b_d1 ? 1 : 2;
        nb++;
        compared++;
        assert (qb.size() != 0 && !(b_d1 && b_d2)) else begin
          mismatched++;
          $error("FAIL b_done observed=%b%b expected=single_expected_pulse", b_d1, b_d2);
        end
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          compared++;
          assert ({b_d1, b_d2, b_p1, b_p2, b_w1, b_w2, b_gs} === eb) else begin
            mismatched++;
            $error("FAIL b_dart observed=%h expected=%h", {b_d1, b_d2, b_p1, b_p2, b_w1, b_w2, b_gs}, eb);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_p1", a_p1, 301);
    chk("rst_a_p2", a_p2, 301);
    chk("rst_b_p1", b_p1, 60);
    chk("rst_b_p2", b_p2, 60);
    chk("rst_flags", {a_gs, a_d1, a_d2, a_w1, a_w2, b_gs, b_d1, b_d2, b_w1, b_w2}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_pulse", last_a + last_b, 0);
    throw(14, 14);
    chk("a_p1_251", a_p1, 251);
    throw(14, 14);
    chk("a_p1_201", a_p1, 201);
    throw(14, 14);
    chk("a_p1_151", a_p1, 151);
    throw(14, 4);
    chk("a_p2_271", a_p2, 271);
    chk("a_p2_done", last_a, 2);
    do_reset();
    throw(14, 14);
    chk("b_p1_10", b_p1, 10);
    throw(14, 4);
    chk("b_bust_p1", b_p1, 60);
    throw(14, 14);
    chk("b_p2_turn", last_b, 2);
    do_reset();
    throw(14, 14);
    throw(14, 7);
    n0 = nb;
`ifdef DOUBLE_OUT_EN
    chk("b_dbl_bust_p1", b_p1, 60);
    chk("b_dbl_no_set", b_gs, 0);
    throw(14, 29);
    chk("b_miss_p2_done", last_b, 2);
    chk("b_miss_p2_pt", b_p2, 60);
    chk("b_miss_pulsed", nb, n0 + 1);
`else
    chk("b_win_p1", b_p1, 0);
    chk("b_win_flags", {b_w1, b_w2, b_gs}, 3'b101);
    throw(14, 29);
    throw(14, 14);
    chk("b_over_no_pulse", nb, n0);
    chk("b_over_held", {b_w1, b_w2, b_gs, b_p1}, {3'b101, 9'd0});
`endif
    @(negedge clk);
    come = 1'b1; px = 8'd14; py = 8'd14;
    @(posedge clk);
    #1 come = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_a", {a_p1, a_p2}, {9'd301, 9'd301});
    chk("midrst_b", {b_p1, b_p2}, {9'd60, 9'd60});
    chk("midrst_flags", {a_gs, a_d1, a_d2, a_w1, a_w2, b_gs, b_d1, b_d2, b_w1, b_w2}, 0);
    model_reset();
    n0 = nb;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_pulse", nb, n0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
